data_mem_responder: RTL
=======================

# data_mem_responder

Responder end of the core's data-memory port: accepts the core's read/write requests (`mem_ren`/`mem_wen`/`mem_addr`/`mem_dout`), services them from an internal word array after a configurable number of wait states, and returns read data with a one-cycle acknowledge. While a request is pending it drives a stall so the pipeline freezes. It replaces the zero-latency data RAM where slower backing memory must be modelled, and it flags misaligned word accesses.

## Interface
- `ADDR_WIDTH`, 10: word-address width; the array holds 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, 2: wait states inserted between request capture and completion (0–15).
- `clk`  input  1  main clock; all state changes on the rising edge.
- `rst`  input  1  reset; synchronous and active-high.
- `mem_ren`  input  1  read request from core; held until `mem_ack`.
- `mem_wen`  input  1  write request from core; held until `mem_ack`; wins over `mem_ren`.
- `mem_addr`  input  32  byte address; word index = `mem_addr[ADDR_WIDTH+1:2]`.
- `mem_din`  input  32  write data from core (core's `mem_dout`).
- `mem_dout`  output  32  read data to core; valid while `mem_ack`=1.
- `mem_ack`  output  1  one-cycle completion pulse.
- `mem_err`  output  1  misaligned access; valid while `mem_ack`=1.
- `mem_stall`  output  1  `(mem_ren|mem_wen) & ~mem_ack`, combinational.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE: on an edge where `mem_ren|mem_wen`, latch op (write if `mem_wen`), word index, write data, and `misaligned = |mem_addr[1:0]`. Load the wait counter with WAIT_CYCLES. Go to WAIT, or straight to DONE if WAIT_CYCLES=0.
- WAIT: decrement the counter each edge. When it reaches 0, go to DONE.
- Commit edge (the edge entering DONE):
  - Aligned write: store the latched data into the array.
  - Aligned read: register the array word into `mem_dout`.
  - Misaligned access: no array access; `mem_dout`←0, `mem_err`←1.
- DONE: `mem_ack`=1 for exactly one cycle, then return to IDLE unconditionally.
- A request still asserted in the cycle after DONE is captured as a new request. The core must advance or drop it during the ack cycle.
- Address bits above `ADDR_WIDTH+1` are ignored, so addresses alias (wrap).
- Request inputs are sampled only in IDLE. Changes during WAIT/DONE have no effect; the latched values are used.
- Read-after-write to the same word in back-to-back requests returns the new data.
- The array is not cleared by reset.

## Timing
- Reset values: `mem_ack`=0, `mem_err`=0, `mem_dout`=0, state=IDLE, counter=0.
- Request captured at edge k → `mem_ack` high during cycle k+1+WAIT_CYCLES.
- Stall length is WAIT_CYCLES+1 cycles; `mem_stall` is low during the ack cycle.
- `mem_dout` and `mem_err` hold their values until the next commit edge.
- Reset mid-operation:
  - Any state returns to IDLE with no ack.
  - A write whose commit edge has not occurred is dropped.
  - If `rst` and the commit edge coincide, reset wins and no write occurs.
- Back-to-back requests: one completion per WAIT_CYCLES+2 cycles.

## Structure
- State encodings (`DMR_IDLE`, `DMR_WAIT`, `DMR_DONE`) and the counter width (4) go in `define.vh`.
- Storage is a sub-module, `data_mem_array`:
  - synchronous write;
  - registered read;
  - ports `clk, we, addr[ADDR_WIDTH-1:0], din, dout`.
- FSM, counter and request latch live in the top module.

## Test plan
- Reset, then idle: `mem_ack`, `mem_err`, `mem_dout` and `mem_stall` all 0.
- Write, WAIT_CYCLES=2: write `0xDEADBEEF` to `0x00000010` at edge k → `mem_stall` high cycles k..k+2, `mem_ack` in cycle k+3.
- Read-back: read `0x00000010` → `mem_dout`=`0xDEADBEEF`, `mem_err`=0.
- Read-after-write: write `0x12345678` to `0x20`, immediately read `0x20` → `0x12345678`.
- Misaligned write `0x00000012` with data `0x55AA55AA`:
  - ack with `mem_err`=1, `mem_dout`=0;
  - a later read of `0x10` still returns `0xDEADBEEF`.
- Reset mid-WAIT: write `0xCAFEF00D` to `0x40`, assert `rst` one cycle after capture → no ack, back to IDLE; a later read of `0x40` returns the prior contents.
- Aliasing: with ADDR_WIDTH=10, write `0xA5A5A5A5` to `0x00001000` (bits above `ADDR_WIDTH+1` only) → read of `0x0` returns `0xA5A5A5A5`.
- Simultaneous `mem_ren` and `mem_wen` → treated as a write; the array word is updated.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared state encoding, counter width and address helper
package data_mem_responder_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        DMR_IDLE = 2'd0,
        DMR_WAIT = 2'd1,
        DMR_DONE = 2'd2
    } dmr_state_t;

    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return |byte_off;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - core data-memory port bundle
interface data_mem_responder_if;

    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_ack;
    logic        mem_err;
    logic        mem_stall;

    modport master (
        output mem_ren, mem_wen, mem_addr, mem_din,
        input  mem_dout, mem_ack, mem_err, mem_stall
    );

    modport slave (
        input  mem_ren, mem_wen, mem_addr, mem_din,
        output mem_dout, mem_ack, mem_err, mem_stall
    );

endinterface

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - word array with synchronous write and registered read
module data_mem_array #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           din,
    output logic [31:0]           dout
);

    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Read returns the pre-write word when we and a read hit the same edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-state data-memory responder with stall, ack and misalign flag
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    data_mem_responder_if.slave bus
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam bit               NO_WAIT   = (WAIT_CYCLES == 0);

    dmr_state_t            state;
    logic [CNT_W-1:0]      cnt;
    logic                  op_wr_q;
    logic                  mis_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic                  ack_q;
    logic                  err_q;
    logic                  rd_fwd_q;
    logic [31:0]           dout_q;

    logic                  req;
    logic                  in_idle;
    logic                  commit;
    logic                  cur_wr;
    logic                  cur_mis;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic [31:0]           cur_data;
    logic                  arr_we;
    logic [31:0]           arr_dout;

    assign req     = bus.mem_ren | bus.mem_wen;
    assign in_idle = (state == DMR_IDLE);

    // With zero wait states the capture edge is also the commit edge, so the
    // live request bypasses the latch.
    always_comb begin
        cur_wr   = op_wr_q;
        cur_mis  = mis_q;
        cur_idx  = idx_q;
        cur_data = wdata_q;
        if (in_idle) begin
            cur_wr   = bus.mem_wen;
            cur_mis  = is_misaligned(bus.mem_addr[1:0]);
            cur_idx  = bus.mem_addr[ADDR_WIDTH+1:2];
            cur_data = bus.mem_din;
        end
    end

    always_comb begin
        commit = 1'b0;
        if (in_idle && req && NO_WAIT) begin
            commit = 1'b1;
        end else if (state == DMR_WAIT && cnt <= 4'd1) begin
            commit = 1'b1;
        end
    end

    assign arr_we = commit & cur_wr & ~cur_mis & ~rst;

    data_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .addr (cur_idx),
        .din  (cur_data),
        .dout (arr_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DMR_IDLE;
            cnt      <= '0;
            op_wr_q  <= 1'b0;
            mis_q    <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rd_fwd_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            ack_q <= commit;

            // A read's data lives in the array's output register during the
            // ack cycle and is copied into dout_q as DONE is left.
            if (commit) begin
                err_q    <= cur_mis;
                rd_fwd_q <= ~cur_wr & ~cur_mis;
                if (cur_mis) begin
                    dout_q <= '0;
                end
            end else if (state == DMR_DONE) begin
                if (rd_fwd_q) begin
                    dout_q <= arr_dout;
                end
                rd_fwd_q <= 1'b0;
            end

            case (state)
                DMR_IDLE: begin
                    if (req) begin
                        op_wr_q <= bus.mem_wen;
                        mis_q   <= is_misaligned(bus.mem_addr[1:0]);
                        idx_q   <= bus.mem_addr[ADDR_WIDTH+1:2];
                        wdata_q <= bus.mem_din;
                        cnt     <= WAIT_LOAD;
                        state   <= NO_WAIT ? DMR_DONE : DMR_WAIT;
                    end
                end
                DMR_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state <= DMR_DONE;
                    end
                end
                DMR_DONE: begin
                    state <= DMR_IDLE;
                end
                default: begin
                    state <= DMR_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_ack   = ack_q;
    assign bus.mem_err   = err_q;
    assign bus.mem_dout  = rd_fwd_q ? arr_dout : dout_q;
    assign bus.mem_stall = req & ~ack_q;

endmodule
